// File: rtl/cpu_sys_oci_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sys_oci_trace_pkg
//  Description : Shared types, constants and helper functions for the OCI
//                data-trace monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_sys_oci_trace_pkg;

    // Monitor lifecycle: record, hold, unload, finished
    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        FROZEN  = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } trace_state_t;

    localparam int DROP_CNT_W = 16;

    // Ceiling log2 for elaboration-time sizing
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of one stored trace entry {count, payload}
    function automatic int entry_width(input int count_w, input int dct_w);
        return count_w + dct_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sys_oci_trace_ram.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sys_oci_trace_ram
//  Description : Simple dual-port RAM, one write port and one registered read
//                port, no reset. Kept separate so a vendor macro can replace it.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sys_oci_trace_ram #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 34,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port plus registered read; read data holds when not enabled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_sys_nios2_oci_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sys_nios2_oci_trace_monitor
//  Description : Captures Nios II OCI DCT samples into a circular buffer,
//                freezes on test end and drains oldest-first over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sys_nios2_oci_trace_monitor
    import cpu_sys_oci_trace_pkg::*;
#(
    parameter int DCT_WIDTH   = 30,
    parameter int COUNT_WIDTH = 4,
    parameter int DEPTH       = 16,
    parameter int WRAP_MODE   = 1
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [DCT_WIDTH-1:0]                     dct_buffer,
    input  logic [COUNT_WIDTH-1:0]                   dct_count,
    input  logic                                     dct_strobe,
    input  logic                                     test_ending,
    input  logic                                     test_has_ended,
    input  logic                                     rd_ready,
    output logic                                     rd_valid,
    output logic [entry_width(COUNT_WIDTH, DCT_WIDTH)-1:0] rd_data,
    output logic [clog2(DEPTH):0]                    entries,
    output logic [DROP_CNT_W-1:0]                    dropped,
    output logic                                     overflow,
    output logic                                     trace_done
);

    localparam int AW = clog2(DEPTH);
    localparam int EW = entry_width(COUNT_WIDTH, DCT_WIDTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    trace_state_t  state;
    trace_state_t  state_next;
    logic          capture_en;
    logic          drain_en;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          capture;
    logic          wr_en;
    logic          overwrite;
    logic          rd_issue;
    logic [EW-1:0] ram_q;

    // A zero-count strobe carries no trace items and is simply ignored
    assign full      = (entries == FULL_LEVEL);
    assign capture   = capture_en && dct_strobe && (dct_count != '0);
    assign wr_en     = capture && (!full || (WRAP_MODE != 0));
    assign overwrite = capture && full && (WRAP_MODE != 0);
    // Refill the output register whenever it is empty or being emptied now
    assign rd_issue  = drain_en && (!rd_valid || rd_ready) && (entries != '0);
    // Output register contents are only meaningful while valid
    assign rd_data   = rd_valid ? ram_q : '0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CAPTURE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; test_has_ended wins over test_ending in CAPTURE
    always_comb begin
        state_next = state;
        case (state)
            CAPTURE: begin
                if (test_has_ended) begin
                    state_next = DRAIN;
                end else if (test_ending) begin
                    state_next = FROZEN;
                end
            end
            FROZEN: begin
                if (test_has_ended) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((entries == '0) && !rd_valid) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = CAPTURE;
        endcase
    end

    // State-derived enables and completion flag
    always_comb begin
        capture_en = 1'b0;
        drain_en   = 1'b0;
        trace_done = 1'b0;
        case (state)
            CAPTURE: capture_en = 1'b1;
            DRAIN:   drain_en   = 1'b1;
            DONE:    trace_done = 1'b1;
            default: ;
        endcase
    end

    // Pointers, occupancy and loss accounting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            entries  <= '0;
            dropped  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            // An overwrite discards the oldest entry, so the tail moves too
            if (rd_issue || overwrite) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (capture && !full) begin
                entries <= entries + (AW + 1)'(1);
            end else if (rd_issue) begin
                entries <= entries - (AW + 1)'(1);
            end
            if (capture && full) begin
                overflow <= 1'b1;
                if (dropped != '1) begin
                    dropped <= dropped + DROP_CNT_W'(1);
                end
            end
        end
    end

    // Output valid: set by a read issue, cleared by a completed transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
        end else if (rd_issue) begin
            rd_valid <= 1'b1;
        end else if (rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

    cpu_sys_oci_trace_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (EW),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({dct_count, dct_buffer}),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_cpu_sys_nios2_oci_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sys_nios2_oci_trace_monitor
//  Description : Self-checking bench; a wrap-mode and a stop-mode instance
//                share stimulus and are checked against queue models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sys_nios2_oci_trace_monitor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [29:0] dct_buffer = '0;
    logic [3:0]  dct_count = '0;
    logic        dct_strobe = 1'b0;
    logic        test_ending = 1'b0;
    logic        test_has_ended = 1'b0;
    logic        rd_ready = 1'b0;

    logic        w_rd_valid, s_rd_valid;
    logic [33:0] w_rd_data, s_rd_data;
    logic [2:0]  w_entries, s_entries;
    logic [15:0] w_dropped, s_dropped;
    logic        w_overflow, s_overflow;
    logic        w_trace_done, s_trace_done;

    int tests = 0;
    int fails = 0;

    // Reference models: ordered contents of the buffer plus loss counters
    logic [33:0] mq_w[$];
    logic [33:0] mq_s[$];
    int          md_w, md_s;
    bit          mo_w, mo_s;

    // Drained words and the drain-loop cycle index of each transfer
    logic [33:0] got_w[$];
    logic [33:0] got_s[$];
    int          cyc_w[$];

    always #5 clk = ~clk;

    cpu_sys_nios2_oci_trace_monitor #(
        .DCT_WIDTH(30), .COUNT_WIDTH(4), .DEPTH(4), .WRAP_MODE(1)
    ) u_wrap (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_strobe(dct_strobe), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_ready(rd_ready), .rd_valid(w_rd_valid), .rd_data(w_rd_data),
        .entries(w_entries), .dropped(w_dropped), .overflow(w_overflow),
        .trace_done(w_trace_done)
    );

    cpu_sys_nios2_oci_trace_monitor #(
        .DCT_WIDTH(30), .COUNT_WIDTH(4), .DEPTH(4), .WRAP_MODE(0)
    ) u_stop (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_strobe(dct_strobe), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_ready(rd_ready), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .entries(s_entries), .dropped(s_dropped), .overflow(s_overflow),
        .trace_done(s_trace_done)
    );

    task automatic model_reset();
        mq_w.delete(); mq_s.delete();
        md_w = 0; md_s = 0; mo_w = 0; mo_s = 0;
    endtask

    // Abstract capture rule: keep newest DEPTH (wrap) or first DEPTH (stop)
    task automatic model_capture(input logic [29:0] data, input logic [3:0] cnt);
        if (cnt == 4'd0) return;
        if (mq_w.size() < 4) mq_w.push_back({cnt, data});
        else begin
            void'(mq_w.pop_front());
            mq_w.push_back({cnt, data});
            md_w++; mo_w = 1;
        end
        if (mq_s.size() < 4) mq_s.push_back({cnt, data});
        else begin
            md_s++; mo_s = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        dct_strobe = 0; dct_count = 0; dct_buffer = 0;
        test_ending = 0; test_has_ended = 0; rd_ready = 0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // One input cycle; the model is told only when capture is expected
    task automatic cap_cycle(input bit stb, input logic [29:0] data,
                             input logic [3:0] cnt, input bit model_on);
        @(negedge clk);
        dct_strobe = stb; dct_buffer = data; dct_count = cnt;
        if (stb && model_on) model_capture(data, cnt);
    endtask

    task automatic idle();
        @(negedge clk);
        dct_strobe = 1'b0;
    endtask

    // Start the drain and record every transfer until both instances finish
    task automatic run_drain(input bit rand_ready, input int budget, output bit timed_out);
        got_w.delete(); got_s.delete(); cyc_w.delete();
        @(negedge clk);
        test_has_ended = 1'b1;
        dct_strobe = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            rd_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (w_rd_valid && rd_ready) begin
                got_w.push_back(w_rd_data);
                cyc_w.push_back(c);
            end
            if (s_rd_valid && rd_ready) got_s.push_back(s_rd_data);
            if (w_trace_done && s_trace_done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests++;
        if ({w_rd_valid, w_entries, w_dropped, w_overflow, w_trace_done, w_rd_data} !== '0) begin
            fails++;
            $display("FAIL reset_wrap: got valid=%0b ent=%0d drop=%0d ovf=%0b done=%0b data=%0h required all 0",
                     w_rd_valid, w_entries, w_dropped, w_overflow, w_trace_done, w_rd_data);
        end
        tests++;
        if ({s_rd_valid, s_entries, s_dropped, s_overflow, s_trace_done, s_rd_data} !== '0) begin
            fails++;
            $display("FAIL reset_stop: got valid=%0b ent=%0d drop=%0d ovf=%0b done=%0b data=%0h required all 0",
                     s_rd_valid, s_entries, s_dropped, s_overflow, s_trace_done, s_rd_data);
        end
    endtask

    task automatic test_basic();
        bit to;
        do_reset();
        for (int i = 1; i <= 3; i++) cap_cycle(1'b1, 30'(i), 4'd1, 1'b1);
        @(negedge clk);
        dct_strobe = 1'b0; test_ending = 1'b1;
        idle();
        tests++;
        if (w_entries !== 3'd3 || w_rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_entries: got %0d valid %0b required 3 valid 0", w_entries, w_rd_valid);
        end
        run_drain(1'b0, 40, to);
        tests++;
        if (to) begin fails++; $display("FAIL basic_timeout: got no trace_done required trace_done=1"); end
        tests++;
        if (got_w.size() != 3) begin
            fails++;
            $display("FAIL basic_count: got %0d required 3", got_w.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (got_w[i] !== {4'd1, 30'(i + 1)}) begin
                    fails++;
                    $display("FAIL basic_data[%0d]: got %0h required %0h", i, got_w[i], {4'd1, 30'(i + 1)});
                end
            end
            tests++;
            if (cyc_w[0] != 1 || cyc_w[1] != 2 || cyc_w[2] != 3) begin
                fails++;
                $display("FAIL basic_timing: got cycles %0d,%0d,%0d required 1,2,3", cyc_w[0], cyc_w[1], cyc_w[2]);
            end
        end
        tests++;
        if (w_trace_done !== 1'b1 || w_overflow !== 1'b0 || w_dropped !== 16'd0) begin
            fails++;
            $display("FAIL basic_final: got done=%0b ovf=%0b drop=%0d required 1,0,0", w_trace_done, w_overflow, w_dropped);
        end
    endtask

    // Wrap and stop policies exercised together on the same six samples
    task automatic test_wrap_and_stop();
        bit to;
        do_reset();
        for (int i = 0; i < 6; i++) cap_cycle(1'b1, 30'(16 + i), 4'd1, 1'b1);
        idle();
        tests++;
        if (w_entries !== 3'd4 || w_dropped !== 16'd2 || w_overflow !== 1'b1) begin
            fails++;
            $display("FAIL wrap_status: got ent=%0d drop=%0d ovf=%0b required 4,2,1", w_entries, w_dropped, w_overflow);
        end
        tests++;
        if (s_entries !== 3'd4 || s_dropped !== 16'd2 || s_overflow !== 1'b1) begin
            fails++;
            $display("FAIL stop_status: got ent=%0d drop=%0d ovf=%0b required 4,2,1", s_entries, s_dropped, s_overflow);
        end
        run_drain(1'b1, 80, to);
        tests++;
        if (to) begin fails++; $display("FAIL wrap_timeout: got no trace_done required trace_done=1"); end
        tests++;
        if (got_w.size() != 4 || got_s.size() != 4) begin
            fails++;
            $display("FAIL wrap_stop_count: got %0d/%0d required 4/4", got_w.size(), got_s.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (got_w[i] !== {4'd1, 30'(18 + i)} || got_w[i] !== mq_w[i]) begin
                    fails++;
                    $display("FAIL wrap_data[%0d]: got %0h required %0h", i, got_w[i], {4'd1, 30'(18 + i)});
                end
                tests++;
                if (got_s[i] !== {4'd1, 30'(16 + i)} || got_s[i] !== mq_s[i]) begin
                    fails++;
                    $display("FAIL stop_data[%0d]: got %0h required %0h", i, got_s[i], {4'd1, 30'(16 + i)});
                end
            end
        end
    endtask

    task automatic test_filter_freeze();
        bit to;
        do_reset();
        cap_cycle(1'b1, 30'h77, 4'd0, 1'b1);
        cap_cycle(1'b1, 30'hAA, 4'd3, 1'b1);
        @(negedge clk);
        dct_strobe = 1'b0; test_ending = 1'b1;
        cap_cycle(1'b1, 30'hB1, 4'd2, 1'b0);
        cap_cycle(1'b1, 30'hB2, 4'd2, 1'b0);
        idle();
        tests++;
        if (w_entries !== 3'd1 || w_dropped !== 16'd0 || s_entries !== 3'd1) begin
            fails++;
            $display("FAIL freeze_status: got ent=%0d/%0d drop=%0d required 1/1 and 0", w_entries, s_entries, w_dropped);
        end
        run_drain(1'b1, 40, to);
        tests++;
        if (to || got_w.size() != 1 || got_w[0] !== {4'd3, 30'hAA}) begin
            fails++;
            $display("FAIL freeze_data: got %0d words first %0h required 1 word %0h",
                     got_w.size(), (got_w.size() > 0) ? got_w[0] : 34'h0, {4'd3, 30'hAA});
        end
    endtask

    task automatic test_backpressure();
        bit to;
        bit seen;
        do_reset();
        cap_cycle(1'b1, 30'h101, 4'd5, 1'b1);
        cap_cycle(1'b1, 30'h202, 4'd6, 1'b1);
        @(negedge clk);
        dct_strobe = 1'b0; test_has_ended = 1'b1; rd_ready = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (w_rd_valid) seen = 1;
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL bp_valid: got rd_valid=0 required 1 within 10 cycles"); end
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (w_rd_valid !== 1'b1 || w_rd_data !== mq_w[0]) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got valid=%0b data=%0h required 1 %0h", c, w_rd_valid, w_rd_data, mq_w[0]);
            end
            @(negedge clk);
        end
        run_drain(1'b0, 40, to);
        tests++;
        if (to || got_w.size() != 2 || got_w[0] !== mq_w[0] || got_w[1] !== mq_w[1]) begin
            fails++;
            $display("FAIL bp_drain: got %0d words timeout=%0b required %0h then %0h",
                     got_w.size(), to, mq_w[0], mq_w[1]);
        end
    endtask

    task automatic test_reset_mid_drain();
        bit to;
        bit seen;
        logic [33:0] first;
        do_reset();
        for (int i = 0; i < 4; i++) cap_cycle(1'b1, 30'(32 + i), 4'd2, 1'b1);
        @(negedge clk);
        dct_strobe = 1'b0; test_has_ended = 1'b1; rd_ready = 1'b1;
        seen = 0; first = '0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (w_rd_valid) begin seen = 1; first = w_rd_data; end
        end
        tests++;
        if (!seen || first !== mq_w[0]) begin
            fails++;
            $display("FAIL rst_first: got seen=%0b data=%0h required %0h", seen, first, mq_w[0]);
        end
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if (w_rd_valid !== 1'b0 || w_entries !== 3'd0 || w_trace_done !== 1'b0 || w_rd_data !== '0) begin
            fails++;
            $display("FAIL rst_mid: got valid=%0b ent=%0d done=%0b data=%0h required 0,0,0,0",
                     w_rd_valid, w_entries, w_trace_done, w_rd_data);
        end
        @(negedge clk);
        test_has_ended = 1'b0; rd_ready = 1'b0; reset_n = 1'b1;
        model_reset();
        cap_cycle(1'b1, 30'h55, 4'd1, 1'b1);
        run_drain(1'b0, 40, to);
        tests++;
        if (to || got_w.size() != 1 || got_w[0] !== {4'd1, 30'h55}) begin
            fails++;
            $display("FAIL rst_after: got %0d words timeout=%0b required single %0h", got_w.size(), to, {4'd1, 30'h55});
        end
    endtask

    // Random samples, random freeze point, random consumer stalls
    task automatic test_random();
        bit to;
        bit frozen;
        int n;
        int frz_at;
        logic [3:0] cnt;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            n = $urandom_range(0, 10);
            frz_at = $urandom_range(0, n + 2);
            frozen = 0;
            for (int i = 0; i < n; i++) begin
                cnt = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                cap_cycle($urandom_range(0, 3) != 0, 30'($urandom), cnt, !frozen);
                if (i == frz_at) begin test_ending = 1'b1; frozen = 1; end
                if (i == n - 1 && $urandom_range(0, 1) == 1) test_has_ended = 1'b1;
            end
            run_drain(1'b1, 120, to);
            tests++;
            if (to) begin fails++; $display("FAIL rand_timeout[%0d]: got no trace_done required 1", it); end
            tests++;
            if (got_w.size() != mq_w.size() || got_s.size() != mq_s.size()) begin
                fails++;
                $display("FAIL rand_count[%0d]: got %0d/%0d required %0d/%0d",
                         it, got_w.size(), got_s.size(), mq_w.size(), mq_s.size());
            end else begin
                for (int i = 0; i < got_w.size(); i++) begin
                    tests++;
                    if (got_w[i] !== mq_w[i]) begin
                        fails++;
                        $display("FAIL rand_wrap[%0d.%0d]: got %0h required %0h", it, i, got_w[i], mq_w[i]);
                    end
                end
                for (int i = 0; i < got_s.size(); i++) begin
                    tests++;
                    if (got_s[i] !== mq_s[i]) begin
                        fails++;
                        $display("FAIL rand_stop[%0d.%0d]: got %0h required %0h", it, i, got_s[i], mq_s[i]);
                    end
                end
            end
            tests++;
            if (w_dropped !== 16'(md_w) || w_overflow !== mo_w || s_dropped !== 16'(md_s) || s_overflow !== mo_s) begin
                fails++;
                $display("FAIL rand_loss[%0d]: got %0d/%0b %0d/%0b required %0d/%0b %0d/%0b", it,
                         w_dropped, w_overflow, s_dropped, s_overflow, md_w, mo_w, md_s, mo_s);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_wrap_and_stop();
        test_filter_freeze();
        test_backpressure();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
